// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the CPU bus arbiter: FSM state encoding and
// transceiver direction codes.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN  = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  localparam logic DIR_B2A = 1'b0;
  localparam logic DIR_A2B = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted candidate at or above ptr,
// wrapping around, reported as a one-hot winner plus a valid flag.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] cand,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               valid
);

  int unsigned idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!valid && cand[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared 8-bit bus transceiver; drives OE_n/DIR and
// inserts an isolation gap whenever the transfer direction flips.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] dir_req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               oe_n,
  output logic               dir,
  output logic               busy,
  output logic               timeout
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned TW = 2;

  state_e              state_q, state_d;
  logic [PW-1:0]       w_q, w_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [TW-1:0]       turn_q, turn_d;
  logic [NUM_REQ-1:0]  stale_q, stale_d;
  logic [NUM_REQ-1:0]  gnt_d;
  logic                oe_n_d, dir_d, busy_d, timeout_d;

  logic [NUM_REQ-1:0]  cand, pick_win;
  logic                pick_valid;
  logic [PW-1:0]       pick_idx;
  logic [PW-1:0]       w_next;
  logic [NUM_REQ-1:0]  w_onehot;

  assign cand = req & ~stale_q;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_picker (
    .cand  (cand),
    .ptr   (rr_ptr_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_win[i]) pick_idx = PW'(i);
    end
  end

  always_comb begin
    w_onehot      = '0;
    w_onehot[w_q] = 1'b1;
    w_next        = (w_q == PW'(NUM_REQ - 1)) ? '0 : PW'(w_q + PW'(1));
  end

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    // A stale requester is forgiven as soon as it drops its request.
    stale_d   = stale_q & req;
    gnt_d     = gnt;
    oe_n_d    = oe_n;
    dir_d     = dir;
    busy_d    = busy;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gnt_d  = '0;
        oe_n_d = 1'b1;
        busy_d = 1'b0;
        if (pick_valid) begin
          w_d    = pick_idx;
          busy_d = 1'b1;
          if (dir_req[pick_idx] == dir) begin
            state_d = ST_GRANT;
            gnt_d   = pick_win;
            oe_n_d  = 1'b0;
            hold_d  = HW'(1);
          end else begin
            // Direction flips while OE_n is still high; GRANT follows after TURN_CYC.
            state_d = ST_TURN;
            dir_d   = dir_req[pick_idx];
            turn_d  = TW'(TURN_CYC - 1);
          end
        end
      end

      ST_TURN: begin
        if (!req[w_q]) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (turn_q == '0) begin
          state_d = ST_GRANT;
          gnt_d   = w_onehot;
          oe_n_d  = 1'b0;
          hold_d  = HW'(1);
        end else begin
          turn_d = turn_q - TW'(1);
        end
      end

      ST_GRANT: begin
        if (!req[w_q] || hold_q >= HW'(MAX_HOLD)) begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          oe_n_d   = 1'b1;
          busy_d   = 1'b0;
          hold_d   = '0;
          rr_ptr_d = w_next;
          if (req[w_q]) begin
            timeout_d      = 1'b1;
            stale_d[w_q]   = 1'b1;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        oe_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      w_q      <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      turn_q   <= '0;
      stale_q  <= '0;
      gnt      <= '0;
      oe_n     <= 1'b1;
      dir      <= DIR_B2A;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      stale_q  <= stale_d;
      gnt      <= gnt_d;
      oe_n     <= oe_n_d;
      dir      <= dir_d;
      busy     <= busy_d;
      timeout  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table plus hand-written sequences
// for round-robin order, timeout/stale, TURN abort and asynchronous reset.
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] dir_req;
  logic [3:0] gnt;
  logic       oe_n;
  logic       dir;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] dir_req;
    logic [3:0] gnt;
    logic       oe_n;
    logic       dir;
    logic       busy;
    logic       timeout;
  } vec_t;

  vec_t vecs[13];

  bus_arbiter #(
    .NUM_REQ  (4),
    .TURN_CYC (1),
    .MAX_HOLD (15)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .dir_req (dir_req),
    .gnt     (gnt),
    .oe_n    (oe_n),
    .dir     (dir),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] eg, input logic eo,
                         input logic ed, input logic eb, input logic et);
    check(name, {24'd0, gnt, oe_n, dir, busy, timeout}, {24'd0, eg, eo, ed, eb, et});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req     = '0;
    dir_req = '0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
  endtask

  initial begin
    //            req      dir_req  gnt      oe_n  dir   busy  tmo
    vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'b1001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{4'b1001, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n   = 1'b1;
    req     = '0;
    dir_req = '0;
    #2;
    rst_n   = 1'b0;
    #1;
    chk_out("reset before clock", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset rr_ptr", 32'(dut.rr_ptr_q), 32'd0);

    // Table: single grant, release, direction turn, wrap-around pick.
    for (int i = 0; i < 13; i++) begin
      req     = vecs[i].req;
      dir_req = vecs[i].dir_req;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].oe_n, vecs[i].dir,
              vecs[i].busy, vecs[i].timeout);
      if (i == 3) check("rr_ptr after release of 0", 32'(dut.rr_ptr_q), 32'd1);
    end

    // Round robin with all requesters active.
    do_reset();
    req     = 4'b1111;
    dir_req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      int         w;
      logic [3:0] oh;
      w  = k % 4;
      oh = 4'b0001 << w;
      step();
      chk_out($sformatf("rr grant %0d", k), oh, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk_out($sformatf("rr hold %0d", k), oh, 1'b0, 1'b0, 1'b1, 1'b0);
      req[w] = 1'b0;
      step();
      chk_out($sformatf("rr idle gap %0d", k), 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      req[w] = 1'b1;
    end

    // Forced release after MAX_HOLD, then stale until req drops.
    do_reset();
    req     = 4'b0100;
    dir_req = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      step();
      chk_out($sformatf("hold cycle %0d", i + 1), 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    step();
    chk_out("timeout pulse", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rr_ptr after timeout", 32'(dut.rr_ptr_q), 32'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("stale no regrant %0d", i), 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    req = 4'b0000;
    step();
    chk_out("stale req dropped", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    req = 4'b0100;
    step();
    chk_out("regrant after stale", 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);

    // Request withdrawn during TURN.
    do_reset();
    req     = 4'b0010;
    dir_req = 4'b0010;
    step();
    chk_out("turn entered", 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_out("turn abort", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rr_ptr after abort", 32'(dut.rr_ptr_q), 32'd0);
    step();
    chk_out("after abort idle", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Winner is latched through TURN even if other requests appear.
    do_reset();
    req     = 4'b0010;
    dir_req = 4'b0010;
    step();
    chk_out("turn latch enter", 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    req = 4'b0011;
    step();
    chk_out("turn latched winner", 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of an A->B grant.
    do_reset();
    req     = 4'b0010;
    dir_req = 4'b0010;
    step();
    step();
    chk_out("grant before reset", 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async reset mid grant", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    req   = 4'b0000;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
